// File: rtl/datapath_ctrl.sv
// datapath_ctrl: sequences the control inputs of `datapath` for one 16-bit
// instruction at a time.
//
// Handshake: start is a request and waiting is the ready. An instruction is
// accepted on any rising edge where waiting=1 and start=1; instr is latched on
// that edge. start while waiting=0 is ignored and never remembered.
module datapath_ctrl #(
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] instr,
    output logic        waiting,
    output logic        illegal,
    output logic [15:0] datapath_in,
    output logic        wb_sel,
    output logic [2:0]  w_addr,
    output logic        w_en,
    output logic [2:0]  r_addr,
    output logic        en_A,
    output logic        en_B,
    output logic [1:0]  shift_op,
    output logic        sel_A,
    output logic        sel_B,
    output logic [1:0]  ALU_op,
    output logic        en_C,
    output logic        en_status
);

    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_DECODE    = 3'd1,
        S_WRITE_IMM = 3'd2,
        S_GET_A     = 3'd3,
        S_GET_B     = 3'd4,
        S_EXEC      = 3'd5,
        S_WRITE_REG = 3'd6
    } state_t;

    // Last EXEC count value; EXEC_CYCLES is 1..15 so this fits in 4 bits.
    localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYCLES - 1);

    state_t      state;
    state_t      state_nx;
    logic [15:0] instr_q;
    logic [3:0]  exec_cnt;
    logic [3:0]  exec_cnt_nx;

    // Instruction fields of the latched instruction.
    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [1:0] sh;
    logic [2:0] rm;
    logic       is_mov_imm;
    logic       is_mov_reg;
    logic       is_alu;
    logic       is_cmp;
    logic       is_mvn;
    logic [1:0] exec_alu_op;

    assign opcode      = instr_q[15:13];
    assign op          = instr_q[12:11];
    assign rn          = instr_q[10:8];
    assign rd          = instr_q[7:5];
    assign sh          = instr_q[4:3];
    assign rm          = instr_q[2:0];
    assign is_mov_imm  = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg  = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu      = (opcode == 3'b101);
    assign is_cmp      = is_alu && (op == 2'b01);
    assign is_mvn      = is_alu && (op == 2'b11);
    // MOV reg runs as 0 + shifted Rm, so it uses ADD with A forced to zero.
    assign exec_alu_op = is_mov_reg ? 2'b00 : op;

    // State register, instruction latch and EXEC cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_WAIT;
            instr_q  <= 16'h0000;
            exec_cnt <= 4'd0;
        end else begin
            state    <= state_nx;
            exec_cnt <= exec_cnt_nx;
            if (state == S_WAIT && start) begin
                instr_q <= instr;
            end
        end
    end

    // Next-state decode and per-state control outputs.
    always_comb begin
        state_nx    = state;
        exec_cnt_nx = exec_cnt;
        waiting     = 1'b0;
        illegal     = 1'b0;
        datapath_in = {{8{instr_q[7]}}, instr_q[7:0]};
        wb_sel      = 1'b0;
        w_addr      = 3'd0;
        w_en        = 1'b0;
        r_addr      = 3'd0;
        en_A        = 1'b0;
        en_B        = 1'b0;
        shift_op    = 2'b00;
        sel_A       = 1'b0;
        sel_B       = 1'b0;
        ALU_op      = 2'b00;
        en_C        = 1'b0;
        en_status   = 1'b0;
        case (state)
            S_WAIT: begin
                waiting = 1'b1;
                if (start) begin
                    state_nx = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_mov_imm) begin
                    state_nx = S_WRITE_IMM;
                end else if (is_mov_reg || is_mvn) begin
                    state_nx = S_GET_B;
                end else if (is_alu) begin
                    state_nx = S_GET_A;
                end else begin
                    illegal  = 1'b1;
                    state_nx = S_WAIT;
                end
            end
            S_WRITE_IMM: begin
                w_en     = 1'b1;
                wb_sel   = 1'b1;
                w_addr   = rn;
                state_nx = S_WAIT;
            end
            S_GET_A: begin
                r_addr   = rn;
                en_A     = 1'b1;
                state_nx = S_GET_B;
            end
            S_GET_B: begin
                r_addr      = rm;
                en_B        = 1'b1;
                exec_cnt_nx = 4'd0;
                state_nx    = S_EXEC;
            end
            S_EXEC: begin
                shift_op  = sh;
                sel_A     = is_mov_reg;
                ALU_op    = exec_alu_op;
                en_C      = !is_cmp;
                en_status = is_cmp;
                if (exec_cnt == EXEC_LAST) begin
                    state_nx = is_cmp ? S_WAIT : S_WRITE_REG;
                end else begin
                    exec_cnt_nx = exec_cnt + 4'd1;
                end
            end
            S_WRITE_REG: begin
                w_en     = 1'b1;
                w_addr   = rd;
                shift_op = sh;
                sel_A    = is_mov_reg;
                ALU_op   = exec_alu_op;
                state_nx = S_WAIT;
            end
            default: begin
                state_nx = S_WAIT;
            end
        endcase
    end

endmodule

// File: doc/datapath_ctrl.md
Name: datapath_ctrl

Overview:
- Control FSM that drives every control input of `datapath` from one 16-bit instruction.
- Replaces the hand-sequenced control used in the datapath bench: it latches an instruction on a start handshake and steps through register read, execute and write-back.
- Sits between the instruction source and `datapath`. The datapath's datapath_out and Z_out are not inputs to this block.

Parameters:
- EXEC_CYCLES, 1, number of cycles EXEC is held with en_C asserted; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request to execute instr; sampled only in WAIT
- instr  input  16  instruction; latched on the accepting edge
- waiting  output  1  high in WAIT only; ready for start
- illegal  output  1  one-cycle pulse when DECODE sees an unsupported encoding
- datapath_in  output  16  sign-extended instr_q[7:0]; driven in every state
- wb_sel  output  1  1 = write back datapath_in, 0 = write back C
- w_addr  output  3  write register
- w_en  output  1  register-file write enable
- r_addr  output  3  read register
- en_A  output  1  load A
- en_B  output  1  load B
- shift_op  output  2  shifter op
- sel_A  output  1  1 = ALU A input forced to 0
- sel_B  output  1  1 = ALU B input is datapath_in
- ALU_op  output  2  00 ADD, 01 SUB, 10 AND, 11 NOT B
- en_C  output  1  load C
- en_status  output  1  load Z

Behaviour:
- Encoding (instr_q): opcode[15:13], op[12:11], Rn[10:8], Rd[7:5], sh[4:3], Rm[2:0], imm8[7:0].
- Supported instructions:
  - 110/10: MOV Rn,#imm8
  - 110/00: MOV Rd,Rm{sh}
  - 101/00: ADD Rd,Rn,Rm{sh}
  - 101/01: CMP Rn,Rm{sh}
  - 101/10: AND Rd,Rn,Rm{sh}
  - 101/11: MVN Rd,Rm{sh}
  - Anything else is illegal.
- Reset (asynchronous, immediate on rst_n low, including mid-instruction):
  - state=WAIT, instr_q=0, exec counter=0.
  - All outputs 0 except waiting=1.
  - No write occurs on the edge on which rst_n rises.
- Defaults: every control output is 0 unless listed for the current state. datapath_in is always sx(imm8).
- WAIT:
  - waiting=1.
  - start=1 at an edge → latch instr into instr_q, go to DECODE.
  - start while not in WAIT is ignored and never queued.
- DECODE: no controls asserted. Next state:
  - MOV imm → WRITE_IMM
  - MOV reg or MVN → GET_B
  - ADD/CMP/AND → GET_A
  - illegal → WAIT, with illegal=1 during DECODE
- WRITE_IMM: w_en=1, wb_sel=1, w_addr=Rn → WAIT.
- GET_A: r_addr=Rn, en_A=1 → GET_B.
- GET_B: r_addr=Rm, en_B=1 → EXEC.
- EXEC, held EXEC_CYCLES cycles via a counter cleared on entry:
  - shift_op=sh; sel_B=0; ALU_op=op[12:11] for opcode 101; ALU_op=00 with sel_A=1 for MOV reg (result 0+shifted Rm); sel_A=0 otherwise.
  - ADD/AND/MVN/MOV reg: en_C=1, en_status=0.
  - CMP: en_C=0, en_status=1.
  - Exit: CMP → WAIT; all others → WRITE_REG.
- WRITE_REG: w_en=1, wb_sel=0, w_addr=Rd; sel_A, ALU_op and shift_op hold their EXEC values → WAIT.
- Latency, with E=EXEC_CYCLES, counted in edges from the start-accept edge to waiting=1:
  - MOV imm: 3
  - MOV reg / MVN: 4+E
  - CMP: 4+E
  - ADD / AND: 5+E
  - Illegal: 2
- Back-to-back operation: start held high in WAIT begins the next instruction on the edge after waiting rises; there are no idle cycles beyond WAIT.
- Register hazards: none, since instructions never overlap.

Test Plan:
- MOV R0,#7 (0xD007), then MOV R1,#2 (0xD102) → one w_en pulse each, wb_sel=1; w_addr=0 with datapath_in=0x0007, then w_addr=1 with datapath_in=0x0002; waiting returns after 3 edges.
- ADD R2,R0,R1 (0xA041) with the bench datapath connected → datapath_out=0x0009 after EXEC; R2 written in WRITE_REG; waiting after 6 edges (E=1).
- CMP R0,R0 (0xA800) → en_C never asserted, en_status=1 for one cycle, Z_out=1, no w_en pulse; MVN R3,R1 (0xB861) → datapath_out=0xFFFD.
- MOV R4,R0,LSL#1 (0xC088) → sel_A=1, shift_op=01, datapath_out=0x000E written to R4; build with EXEC_CYCLES=3 → en_C high for exactly 3 cycles, latency 7.
- instr=0x0000 with start=1 → illegal pulses once, no w_en/en_A/en_B/en_C, waiting after 2 edges; start toggled while busy → ignored.
- rst_n low during GET_B of an ADD → all controls 0 and waiting=1 immediately; after release, a MOV R5,#0xFF (0xD5FF) writes 0xFFFF to R5.
